// File: rtl/mdu_pkg.sv
// Shared types for the HI/LO multiply/accumulate unit.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MUL   = 3'b000,
        MDU_MULU  = 3'b001,
        MDU_MADD  = 3'b010,
        MDU_MADDU = 3'b011,
        MDU_MTHI  = 3'b100,
        MDU_MTLO  = 3'b101
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_FINISH  = 2'd2
    } mdu_state_e;

    localparam int MDU_WIDTH = 32;
    localparam int MDU_CNT_W = $clog2(MDU_WIDTH + 1);

    function automatic int mdu_cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mdu_seq_mult.sv
// Unsigned radix-2 shift-add multiplier core: load captures operands, each step consumes one multiplier bit.
// MDU_EARLY_TERM_EN: raise last as soon as the remaining multiplier bits are all zero.
module mdu_seq_mult
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc,
    output logic               last
);
    localparam int CNT_W = mdu_cnt_width(WIDTH);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] addend;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CNT_W-1:0]   cnt_reg;

    // Partial product: the shifted multiplicand gated by the current multiplier LSB.
    generate
        for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_pp
            assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            mcand_reg  <= {{WIDTH{1'b0}}, mcand};
            mplier_reg <= mplier;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (step) begin
            acc_reg    <= acc_reg + addend;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
        end
    end

`ifdef MDU_EARLY_TERM_EN
    assign last = (cnt_reg == CNT_W'(WIDTH - 1)) || (mplier_reg[WIDTH-1:1] == '0);
`else
    assign last = (cnt_reg == CNT_W'(WIDTH - 1));
`endif

    assign acc = acc_reg;

endmodule

// File: rtl/mdu_hilo.sv
// Sequential multiply/accumulate unit owning the HI/LO pair; stalls the pipeline via busy.
// Optional MDU_EARLY_TERM_EN shortens multiplies whose |b| has few significant bits.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               flush,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic [2*WIDTH-1:0] hi_lo
);
    mdu_state_e state_reg, state_next;
    mdu_op_e    op_dec;

    logic               neg_reg;
    logic               madd_reg;
    logic               done_reg;
    logic [2*WIDTH-1:0] hi_lo_reg;
    logic [2*WIDTH-1:0] hi_lo_next;
    logic [2*WIDTH-1:0] mult_acc;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] madd_sum;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               op_signed;
    logic               mult_load;
    logic               mult_step;
    logic               mult_last;
    logic               commit;
    logic               wr_hi;
    logic               wr_lo;

    assign op_dec    = mdu_op_e'(op);
    assign op_signed = ~op[0];

    // Magnitudes fit unsigned even for the most negative operand.
    assign a_mag = (op_signed && a[WIDTH-1]) ? -a : a;
    assign b_mag = (op_signed && b[WIDTH-1]) ? -b : b;

    mdu_seq_mult #(
        .WIDTH (WIDTH)
    ) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mult_load),
        .step   (mult_step),
        .mcand  (a_mag),
        .mplier (b_mag),
        .acc    (mult_acc),
        .last   (mult_last)
    );

    assign product  = neg_reg ? -mult_acc : mult_acc;
    assign madd_sum = hi_lo_reg + product;

    always_comb begin
        state_next = state_reg;
        mult_load  = 1'b0;
        mult_step  = 1'b0;
        commit     = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op_dec)
                        MDU_MUL, MDU_MULU, MDU_MADD, MDU_MADDU: begin
                            mult_load  = 1'b1;
                            state_next = ST_COMPUTE;
                        end
                        MDU_MTHI: wr_hi = 1'b1;
                        MDU_MTLO: wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_COMPUTE: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else begin
                    mult_step = 1'b1;
                    if (mult_last) begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
                commit     = !flush;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        hi_lo_next = hi_lo_reg;
        if (commit) begin
            hi_lo_next = madd_reg ? madd_sum : product;
        end else if (wr_hi) begin
            hi_lo_next[2*WIDTH-1:WIDTH] = a;
        end else if (wr_lo) begin
            hi_lo_next[WIDTH-1:0] = a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            hi_lo_reg <= '0;
            neg_reg   <= 1'b0;
            madd_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            hi_lo_reg <= hi_lo_next;
            done_reg  <= commit;
            if (mult_load) begin
                neg_reg  <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                madd_reg <= op[1];
            end
        end
    end

    assign busy  = (state_reg != ST_IDLE);
    assign done  = done_reg;
    assign hi_lo = hi_lo_reg;
    assign hi    = hi_lo_reg[2*WIDTH-1:WIDTH];
    assign lo    = hi_lo_reg[WIDTH-1:0];

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: the driver queues expected HI:LO and completion cycle, the monitor checks on done.
module tb_mdu_hilo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] hi_lo;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] hl;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    logic [63:0] model_hl = '0;

    mdu_hilo #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo),
        .hi_lo (hi_lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic int mul_lat(input logic [2:0] o, input logic [31:0] bv);
`ifdef MDU_EARLY_TERM_EN
        logic [31:0] m;
        int hb;
        m  = (!o[0] && bv[31]) ? -bv : bv;
        hb = 0;
        for (int i = 0; i < 32; i++) begin
            if (m[i]) hb = i;
        end
        return hb + 2;
`else
        return 33;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vec_cnt++;
        if (act !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h", nm, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                err_cnt++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, want no done", cyc);
            end else begin
                e = exp_q.pop_front();
                $display("done  cyc=%0d hi_lo=%h expect=%h", cyc, hi_lo, e.hl);
                chk("hi_lo", hi_lo, e.hl);
                chk("hi", {32'h0, hi}, {32'h0, e.hl[63:32]});
                chk("lo", {32'h0, lo}, {32'h0, e.hl[31:0]});
                chk("latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [63:0] exp_hl, input bit push, output int lat);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        lat   = mul_lat(o, bv);
        if (push) begin
            e.hl  = exp_hl;
            e.cyc = cyc + 1 + lat;
            exp_q.push_back(e);
        end
        $display("issue op=%b a=%h b=%h expect=%h push=%0d", o, av, bv, exp_hl, push);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk("busy_after_start", {63'h0, busy}, 64'h1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) begin
            vec_cnt++;
            err_cnt++;
            $display("FAIL wait_idle: got busy=%b after 200 cycles, want 0", busy);
        end
    endtask

    task automatic mul_op(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] exp_hl);
        int lat;
        issue(o, av, bv, exp_hl, 1'b1, lat);
        wait_idle();
        model_hl = exp_hl;
        @(negedge clk);
    endtask

    task automatic mt_op(input logic [2:0] o, input logic [31:0] av);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = av;
        if (o == 3'b100) model_hl[63:32] = av;
        else if (o == 3'b101) model_hl[31:0] = av;
        @(negedge clk);
        start = 1'b0;
        $display("move  op=%b a=%h hi_lo=%h expect=%h", o, av, hi_lo, model_hl);
        chk("move_busy", {63'h0, busy}, 64'h0);
        chk("move_hi_lo", hi_lo, model_hl);
    endtask

    initial begin
        int lat;

        repeat (3) @(negedge clk);
        $display("reset hi_lo=%h busy=%b done=%b", hi_lo, busy, done);
        chk("reset_hi_lo", hi_lo, 64'h0);
        chk("reset_busy", {63'h0, busy}, 64'h0);
        chk("reset_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;

        mul_op(3'b000, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        mul_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        mul_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);

        mt_op(3'b100, 32'h0000_0001);
        mt_op(3'b101, 32'hFFFF_FFFF);
        mul_op(3'b011, 32'd1, 32'd1, 64'h0000_0002_0000_0000);

        mul_op(3'b000, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        mt_op(3'b100, 32'h0);
        mt_op(3'b101, 32'h0);
        mul_op(3'b010, 32'h8000_0000, 32'd1, 64'hFFFF_FFFF_8000_0000);
        mul_op(3'b010, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_7FFF_FFFA);

        // Reserved opcode leaves everything untouched.
        mt_op(3'b110, 32'h0000_0123);

        // Starts while busy, including a move, must be ignored.
        issue(3'b000, 32'd5, 32'h0006_0000, 64'h0000_0000_001E_0000, 1'b1, lat);
        repeat (2) @(negedge clk);
        start = 1'b1; op = 3'b101; a = 32'h0000_DEAD;
        @(negedge clk);
        op = 3'b000; a = 32'd11; b = 32'd13;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        model_hl = 64'h0000_0000_001E_0000;
        repeat (3) @(negedge clk);
        chk("ignored_start_hi_lo", hi_lo, model_hl);

        // Flush after 10 busy cycles: no commit, no done.
        issue(3'b000, 32'd9, 32'h0009_0000, 64'h0, 1'b0, lat);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        $display("flush busy=%b hi_lo=%h", busy, hi_lo);
        chk("flush_busy", {63'h0, busy}, 64'h0);
        chk("flush_hi_lo", hi_lo, model_hl);

        // Flush together with start in IDLE drops the request.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'h0, busy}, 64'h0);
        chk("flush_start_hi_lo", hi_lo, model_hl);

        // Flush landing in FINISH suppresses the commit.
        issue(3'b000, 32'd3, 32'd3, 64'h0, 1'b0, lat);
        repeat (lat - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_finish_busy", {63'h0, busy}, 64'h0);
        repeat (3) @(negedge clk);
        chk("flush_finish_hi_lo", hi_lo, model_hl);

        // Reset mid-compute discards everything.
        issue(3'b000, 32'd4, 32'h8000_0000, 64'h0, 1'b0, lat);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        $display("midreset busy=%b hi_lo=%h done=%b", busy, hi_lo, done);
        chk("midreset_busy", {63'h0, busy}, 64'h0);
        chk("midreset_hi_lo", hi_lo, 64'h0);
        chk("midreset_done", {63'h0, done}, 64'h0);
        rst_n = 1'b1;
        model_hl = '0;

        mul_op(3'b001, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
